// File: rtl/addsub_pipelined.sv
// Pipelined N-bit adder/subtractor: one K-bit slice per stage, carry/borrow rippling
// through the stage registers, valid/ready handshake with bubble collapsing.
module addsub_pipelined #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  input  logic         Mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Difference,
  output logic         Bout,
  output logic         Overflow,
  output logic         Zero
);

  localparam int unsigned STAGES = N / K;

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] adv;
  logic              mode_q [STAGES];
  logic              cy_q   [STAGES];
  logic [N-1:0]      a_q    [STAGES];
  logic [N-1:0]      b_q    [STAGES];
  logic [N-1:0]      res_q  [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_mode;
  logic [STAGES-1:0] src_cy;
  logic [N-1:0]      src_a   [STAGES];
  logic [N-1:0]      src_b   [STAGES];
  logic [N-1:0]      src_res [STAGES];
  logic [N-1:0]      res_d   [STAGES];
  logic [STAGES-1:0] cy_d;
  logic              ovf_d;
  logic              zero_d;

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    logic        chain;
    int unsigned s;
    chain = out_ready;
    adv   = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      s      = STAGES - 1 - i;
      chain  = !valid_q[s] || chain;
      adv[s] = chain;
    end
  end

  assign in_ready   = adv[0];
  assign out_valid  = valid_q[STAGES-1];
  assign Difference = res_q[STAGES-1];
  assign Bout       = cy_q[STAGES-1];
  assign Overflow   = ovf_q;
  assign Zero       = zero_q;

  always_comb begin
    logic [K:0]   t;
    logic [K-1:0] as;
    logic [K-1:0] bs;
    logic [N-1:0] dl;
    logic         am;
    logic         bm;
    t  = '0;
    as = '0;
    bs = '0;
    src_valid[0] = in_valid;
    src_mode[0]  = Mode;
    src_cy[0]    = Bin;
    src_a[0]     = A;
    src_b[0]     = B;
    src_res[0]   = '0;
    for (int unsigned s = 1; s < STAGES; s++) begin
      src_valid[s] = valid_q[s-1];
      src_mode[s]  = mode_q[s-1];
      src_cy[s]    = cy_q[s-1];
      src_a[s]     = a_q[s-1];
      src_b[s]     = b_q[s-1];
      src_res[s]   = res_q[s-1];
    end
    for (int unsigned s = 0; s < STAGES; s++) begin
      as = src_a[s][s*K +: K];
      bs = src_b[s][s*K +: K];
      if (src_mode[s]) t = {1'b0, as} + {1'b0, bs} + {{K{1'b0}}, src_cy[s]};
      else             t = {1'b0, as} - {1'b0, bs} - {{K{1'b0}}, src_cy[s]};
      res_d[s]             = src_res[s];
      res_d[s][s*K +: K]   = t[K-1:0];
      cy_d[s]              = t[K];
    end
    // Flags are registered alongside the final slice so they reset cleanly.
    dl     = res_d[STAGES-1];
    am     = src_a[STAGES-1][N-1];
    bm     = src_b[STAGES-1][N-1];
    zero_d = (dl == '0);
    if (src_mode[STAGES-1]) ovf_d = (am == bm) && (dl[N-1] != am);
    else                    ovf_d = (am != bm) && (dl[N-1] != am);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        mode_q[s] <= 1'b0;
        cy_q[s]   <= 1'b0;
        a_q[s]    <= '0;
        b_q[s]    <= '0;
        res_q[s]  <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (adv[s]) begin
          valid_q[s] <= src_valid[s];
          mode_q[s]  <= src_mode[s];
          cy_q[s]    <= cy_d[s];
          a_q[s]     <= src_a[s];
          b_q[s]     <= src_b[s];
          res_q[s]   <= res_d[s];
        end
      end
      if (adv[STAGES-1]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipelined.sv
// Scoreboard bench for addsub_pipelined (N=8, K=4): directed vectors with
// hand-computed results, a decoupled output monitor, stall and reset scenarios.
module tb_addsub_pipelined;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       Bin;
  logic       Mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Difference;
  logic       Bout;
  logic       Overflow;
  logic       Zero;

  addsub_pipelined #(.N(8), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .Mode(Mode), .out_valid(out_valid),
    .out_ready(out_ready), .Difference(Difference), .Bout(Bout),
    .Overflow(Overflow), .Zero(Zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
    logic       z;
  } exp_t;

  vec_t vecs [14];
  exp_t sb [$];
  int   pop_cyc [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic m, input logic [7:0] a, input logic [7:0] b,
                      input logic bin, input logic [7:0] d, input logic bo, input logic ov,
                      input logic z);
    vecs[i] = {m, a, b, bin, d, bo, ov, z};
  endtask

  task automatic send(input int i, output int waited);
    bit ok;
    ok     = 0;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    Mode     = vecs[i].m;
    A        = vecs[i].a;
    B        = vecs[i].b;
    Bin      = vecs[i].bin;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        sb.push_back({vecs[i].d, vecs[i].bo, vecs[i].ov, vecs[i].z});
        ok = 1;
        break;
      end
      waited++;
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: vector %0d not accepted, required acceptance", i);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 60; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
      #3;
    end
    chk("drain_pending", sb.size(), 0);
  endtask

  // Output monitor: compares on every output transfer, checks stability while stalled.
  initial begin
    exp_t e;
    exp_t hold;
    bit   held;
    held = 0;
    hold = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 0;
      end else if (out_valid && out_ready) begin
        held = 0;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected no output", Difference);
        end else begin
          e = sb.pop_front();
          chk("result", {Difference, Bout, Overflow, Zero}, e);
          pop_cyc.push_back(cyc);
        end
      end else if (out_valid) begin
        if (held) chk("stall_stable", {Difference, Bout, Overflow, Zero}, hold);
        hold = {Difference, Bout, Overflow, Zero};
        held = 1;
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    setv(0,  1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0);
    setv(1,  1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    setv(2,  1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
    setv(3,  1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    setv(4,  1'b0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    setv(5,  1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    setv(6,  1'b0, 8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1, 1'b1, 1'b0);
    setv(7,  1'b1, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0);
    setv(8,  1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    setv(9,  1'b0, 8'hF0, 8'h0F, 1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    setv(10, 1'b1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    setv(11, 1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    setv(12, 1'b1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);
    setv(13, 1'b0, 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Bin = 1'b0; Mode = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_difference", Difference, 0);
    chk("rst_bout", Bout, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_zero", Zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // Latency and isolated vectors
    send(0, w);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("latency_early", out_valid, 0);
    @(negedge clk);
    #1;
    chk("latency_valid", out_valid, 1);
    drain();
    foreach (vecs[i]) begin
      if (i >= 1 && i <= 4 || i == 8) begin
        send(i, w);
        drain();
      end
    end

    // Back-to-back with alternating Mode
    base = pop_cyc.size();
    send(5, w); chk("b2b_in_ready_5", w, 0);
    send(6, w); chk("b2b_in_ready_6", w, 0);
    send(7, w); chk("b2b_in_ready_7", w, 0);
    send(9, w); chk("b2b_in_ready_9", w, 0);
    drain();
    chk("b2b_count", pop_cyc.size() - base, 4);
    if (pop_cyc.size() - base == 4)
      for (int i = 1; i < 4; i++) chk("b2b_consecutive", pop_cyc[base+i] - pop_cyc[base+i-1], 1);

    // Backpressure while feeding
    fork
      begin
        send(10, w); send(11, w); send(12, w); send(13, w);
      end
      begin
        @(negedge clk);
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("full_in_ready", in_ready, 0);
      end
    join
    drain();

    // Reset with two sets in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(1, w);
    send(2, w);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_difference", Difference, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("no_stale_output", out_valid, 0);
    end
    send(0, w);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
